ssp_param: RTL and testbench

SSP_PARAM -- requirements
Module: ssp_param

---
 rtl/ssp_pkg.sv | 16 +
 rtl/ssp_fifo.sv | 49 ++++
 rtl/ssp_param.sv | 235 +++++++++++++++++++++++
 tb/tb_ssp_param.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssp_pkg.sv
// Shared types for the synchronous serial port: Tx/Rx state encoding and
// the FIFO pointer width helper.
package ssp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_SHIFT = 2'd2
    } ssp_state_e;

    // One extra MSB beyond the address bits distinguishes full from empty.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ssp_fifo.sv
// Synchronous FIFO used for both the transmit and receive queues.
// Head word is shown combinationally; reads as zero while empty.
module ssp_fifo
    import ssp_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0] wp, rp;
    logic [DW-1:0] mem [DEPTH];
    logic          do_push, do_pop;

    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);

    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign dout = empty ? '0 : mem[rp[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + PW'(1);
            if (do_pop)  rp <= rp + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ssp_param.sv
// Synchronous serial port: bus-fed Tx FIFO + framed serializer, deserializer
// + Rx FIFO. Define SSP_LOOPBACK_EN to add the LBM internal-loopback input.
module ssp_param
    import ssp_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int DIV   = 1
) (
    input  logic          PCLK,
    input  logic          CLEAR_B,
    input  logic          PSEL,
    input  logic          PWRITE,
    input  logic [DW-1:0] PWDATA,
    output logic [DW-1:0] PRDATA,
    input  logic          SSPCLKIN,
    input  logic          SSPFSSIN,
    input  logic          SSPRXD,
`ifdef SSP_LOOPBACK_EN
    input  logic          LBM,
`endif
    output logic          SSPCLKOUT,
    output logic          SSPFSSOUT,
    output logic          SSPTXD,
    output logic          SSPOE_B,
    output logic          SSPTXINTR,
    output logic          SSPRXINTR,
    output logic          SSPRORINTR
);

    localparam int BW = $clog2(DW);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    // ---------------- serial clock generator ----------------
    logic [CW-1:0] div_cnt;
    logic          sclk, tick, rise;

    assign tick = (div_cnt == CW'(DIV - 1));
    assign rise = tick & ~sclk;

    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (tick) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

    // ---------------- bus side and FIFOs ----------------
    logic          wr, rd;
    logic          tx_pop, tx_full, tx_empty;
    logic [DW-1:0] tx_dout;
    logic          rx_push, rx_full, rx_empty;
    logic [DW-1:0] rx_word;

    assign wr = PSEL & PWRITE;
    assign rd = PSEL & ~PWRITE;

    ssp_fifo #(.DW(DW), .DEPTH(DEPTH)) u_tx_fifo (
        .clk   (PCLK),
        .rst_n (CLEAR_B),
        .push  (wr),
        .din   (PWDATA),
        .pop   (tx_pop),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty)
    );

    ssp_fifo #(.DW(DW), .DEPTH(DEPTH)) u_rx_fifo (
        .clk   (PCLK),
        .rst_n (CLEAR_B),
        .push  (rx_push),
        .din   (rx_word),
        .pop   (rd),
        .dout  (PRDATA),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // ---------------- transmit FSM ----------------
    ssp_state_e    tx_state, tx_state_n;
    logic [DW-1:0] tx_sh, tx_nxt;
    logic [BW-1:0] tx_bit;
    logic          tx_more, tx_fss, tx_last, tx_prelast;

    assign tx_last    = (tx_bit == BW'(DW - 1));
    assign tx_prelast = (tx_bit == BW'(DW - 2));

    // The follow-on word is fetched when entering the LSB period so FSS can
    // flag it during that period and its MSB follows without a gap.
    always_comb begin
        tx_state_n = tx_state;
        tx_pop     = 1'b0;
        if (rise) begin
            case (tx_state)
                ST_IDLE: begin
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_state_n = ST_SYNC;
                    end
                end
                ST_SYNC: tx_state_n = ST_SHIFT;
                ST_SHIFT: begin
                    if (tx_last) begin
                        if (!tx_more) tx_state_n = ST_IDLE;
                    end else if (tx_prelast && !tx_empty) begin
                        tx_pop = 1'b1;
                    end
                end
                default: tx_state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            tx_state <= ST_IDLE;
            tx_sh    <= '0;
            tx_nxt   <= '0;
            tx_bit   <= '0;
            tx_more  <= 1'b0;
            tx_fss   <= 1'b0;
        end else begin
            tx_state <= tx_state_n;
            if (rise) begin
                case (tx_state)
                    ST_IDLE: begin
                        if (tx_pop) begin
                            tx_sh  <= tx_dout;
                            tx_fss <= 1'b1;
                        end
                    end
                    ST_SYNC: begin
                        tx_fss <= 1'b0;
                        tx_bit <= '0;
                    end
                    ST_SHIFT: begin
                        if (tx_last) begin
                            tx_fss  <= 1'b0;
                            tx_more <= 1'b0;
                            tx_bit  <= '0;
                            tx_sh   <= tx_nxt;
                        end else begin
                            tx_sh  <= {tx_sh[DW-2:0], 1'b0};
                            tx_bit <= tx_bit + BW'(1);
                            if (tx_pop) begin
                                tx_nxt  <= tx_dout;
                                tx_more <= 1'b1;
                                tx_fss  <= 1'b1;
                            end
                        end
                    end
                    default: tx_fss <= 1'b0;
                endcase
            end
        end
    end

    assign SSPCLKOUT = sclk;
    assign SSPFSSOUT = tx_fss;
    assign SSPTXD    = (tx_state == ST_SHIFT) & tx_sh[DW-1];
    assign SSPOE_B   = (tx_state != ST_SHIFT);
    assign SSPTXINTR = tx_full;

    // ---------------- receive path ----------------
    logic rx_clk, rx_fss, rx_dat;

`ifdef SSP_LOOPBACK_EN
    assign rx_clk = LBM ? sclk   : SSPCLKIN;
    assign rx_fss = LBM ? tx_fss : SSPFSSIN;
    assign rx_dat = LBM ? SSPTXD : SSPRXD;
`else
    assign rx_clk = SSPCLKIN;
    assign rx_fss = SSPFSSIN;
    assign rx_dat = SSPRXD;
`endif

    ssp_state_e    rx_state, rx_state_n;
    logic          rx_clk_d, rx_fall, rx_last, rx_ovr, ror;
    logic [DW-2:0] rx_sh;
    logic [BW-1:0] rx_cnt;

    assign rx_fall = rx_clk_d & ~rx_clk;
    assign rx_last = (rx_state == ST_SHIFT) && (rx_cnt == BW'(DW - 1));

    // The last bit of a word completes it even when FSS re-arms on that edge.
    always_comb begin
        rx_state_n = rx_state;
        if (rx_fall) begin
            if (rx_fss)       rx_state_n = ST_SHIFT;
            else if (rx_last) rx_state_n = ST_IDLE;
        end
    end

    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            rx_state <= ST_IDLE;
            rx_clk_d <= 1'b0;
            rx_sh    <= '0;
            rx_cnt   <= '0;
            rx_push  <= 1'b0;
            rx_word  <= '0;
        end else begin
            rx_state <= rx_state_n;
            rx_clk_d <= rx_clk;
            rx_push  <= rx_fall & rx_last;
            if (rx_fall & rx_last) rx_word <= {rx_sh, rx_dat};
            if (rx_fall) begin
                if (rx_fss) begin
                    rx_cnt <= '0;
                end else if (rx_state == ST_SHIFT) begin
                    rx_sh  <= {rx_sh[DW-3:0], rx_dat};
                    rx_cnt <= rx_cnt + BW'(1);
                end
            end
        end
    end

    // Overrun only when the completed word cannot enter the FIFO.
    assign rx_ovr = rx_push & rx_full & ~(rd & ~rx_empty);

    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) ror <= 1'b0;
        else          ror <= rx_ovr | (ror & ~rd);
    end

    assign SSPRXINTR  = rx_full;
    assign SSPRORINTR = ror;

endmodule

// File: tb/tb_ssp_param.sv
// Scoreboard bench for ssp_param: expected Tx frames and Rx read data are
// queued by the stimulus and consumed by independent monitors.
module tb_ssp_param;

    localparam int DW = 8;

    logic          PCLK = 1'b0;
    logic          CLEAR_B = 1'b1;
    logic          PSEL = 1'b0;
    logic          PWRITE = 1'b0;
    logic [DW-1:0] PWDATA = '0;
    logic [DW-1:0] PRDATA;
    logic          SSPCLKIN, SSPFSSIN, SSPRXD;
    logic          SSPCLKOUT, SSPFSSOUT, SSPTXD, SSPOE_B;
    logic          SSPTXINTR, SSPRXINTR, SSPRORINTR;

    logic lb_en = 1'b0;
    logic pin_clk = 1'b0, pin_fss = 1'b0, pin_rxd = 1'b0;

`ifdef SSP_LOOPBACK_EN
    assign SSPCLKIN = pin_clk;
    assign SSPFSSIN = pin_fss;
    assign SSPRXD   = pin_rxd;
`else
    assign SSPCLKIN = lb_en ? SSPCLKOUT : pin_clk;
    assign SSPFSSIN = lb_en ? SSPFSSOUT : pin_fss;
    assign SSPRXD   = lb_en ? SSPTXD    : pin_rxd;
`endif

    ssp_param #(.DW(DW), .DEPTH(4), .DIV(1)) dut (
        .PCLK       (PCLK),
        .CLEAR_B    (CLEAR_B),
        .PSEL       (PSEL),
        .PWRITE     (PWRITE),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .SSPCLKIN   (SSPCLKIN),
        .SSPFSSIN   (SSPFSSIN),
        .SSPRXD     (SSPRXD),
`ifdef SSP_LOOPBACK_EN
        .LBM        (lb_en),
`endif
        .SSPCLKOUT  (SSPCLKOUT),
        .SSPFSSOUT  (SSPFSSOUT),
        .SSPTXD     (SSPTXD),
        .SSPOE_B    (SSPOE_B),
        .SSPTXINTR  (SSPTXINTR),
        .SSPRXINTR  (SSPRXINTR),
        .SSPRORINTR (SSPRORINTR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [DW-1:0] d;
        logic          chain;
    } tx_exp_t;

    tx_exp_t       txq[$];
    logic [DW-1:0] rxq[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic bound_fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out", nm);
    endtask

    // Tx monitor: frames start on FSS seen at a serial-clock fall; a frame
    // FSS-flagged in its LSB period must be followed directly by the next.
    logic          sclk_prev = 1'b0, mon_armed = 1'b0, mon_oe_bad = 1'b0;
    int            mon_cnt = 0;
    logic [DW-1:0] mon_word = '0;
    tx_exp_t       mon_e;

    always @(negedge PCLK) begin
        if (!CLEAR_B) begin
            mon_armed  = 1'b0;
            mon_cnt    = 0;
            mon_oe_bad = 1'b0;
            sclk_prev  = 1'b0;
        end else begin
            if (sclk_prev && !SSPCLKOUT) begin
                if (mon_armed) begin
                    mon_word = {mon_word[DW-2:0], SSPTXD};
                    if (SSPOE_B) mon_oe_bad = 1'b1;
                    mon_cnt++;
                    if (mon_cnt == DW) begin
                        if (txq.size() == 0) begin
                            bound_fail("tx_unexpected_frame");
                        end else begin
                            mon_e = txq.pop_front();
                            chk("tx_word", 32'(mon_word), 32'(mon_e.d));
                            chk("tx_fss_in_lsb", 32'(SSPFSSOUT), 32'(mon_e.chain));
                            chk("tx_oe_during_frame", 32'(mon_oe_bad), 32'd0);
                        end
                        mon_armed  = SSPFSSOUT;
                        mon_cnt    = 0;
                        mon_oe_bad = 1'b0;
                    end
                end else if (SSPFSSOUT) begin
                    mon_armed  = 1'b1;
                    mon_cnt    = 0;
                    mon_oe_bad = 1'b0;
                end
            end
            sclk_prev = SSPCLKOUT;
        end
    end

    // Rx monitor: every read strobe is checked against the queued value.
    always @(negedge PCLK) begin
        if (CLEAR_B && PSEL && !PWRITE) begin
            if (rxq.size() == 0) bound_fail("rx_unexpected_read");
            else chk("rx_prdata", 32'(PRDATA), 32'(rxq.pop_front()));
        end
    end

    task automatic push_tx(input logic [DW-1:0] d, input logic c);
        tx_exp_t e;
        e.d = d;
        e.chain = c;
        txq.push_back(e);
    endtask

    task automatic wr(input logic [DW-1:0] d);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PWRITE = 1'b1; PWDATA = d;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic rd_exp(input logic [DW-1:0] d);
        rxq.push_back(d);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PWRITE = 1'b0;
        @(posedge PCLK); #1;
        PSEL = 1'b0;
    endtask

    task automatic wait_tx(input int maxc);
        int n = 0;
        while (txq.size() != 0 && n < maxc) begin
            @(posedge PCLK);
            n++;
        end
        if (txq.size() != 0) begin
            bound_fail("tx_drain");
            txq.delete();
        end
        #1;
    endtask

    task automatic wait_fss(input int maxc);
        int n = 0;
        do begin
            @(negedge PCLK);
            n++;
        end while (!SSPFSSOUT && n < maxc);
        if (!SSPFSSOUT) bound_fail("wait_fss");
    endtask

    task automatic wait_oe(input int maxc);
        int n = 0;
        do begin
            @(negedge PCLK);
            n++;
        end while (SSPOE_B && n < maxc);
        if (SSPOE_B) bound_fail("wait_oe");
    endtask

    task automatic pin_bit(input logic f, input logic d);
        pin_fss = f;
        pin_rxd = d;
        pin_clk = 1'b1;
        repeat (2) @(posedge PCLK);
        #1 pin_clk = 1'b0;
        repeat (2) @(posedge PCLK);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_oe_b"},   32'(SSPOE_B),    32'd1);
        chk({tag, "_txd"},    32'(SSPTXD),     32'd0);
        chk({tag, "_clkout"}, 32'(SSPCLKOUT),  32'd0);
        chk({tag, "_fssout"}, 32'(SSPFSSOUT),  32'd0);
        chk({tag, "_txintr"}, 32'(SSPTXINTR),  32'd0);
        chk({tag, "_rxintr"}, 32'(SSPRXINTR),  32'd0);
        chk({tag, "_ror"},    32'(SSPRORINTR), 32'd0);
        chk({tag, "_prdata"}, 32'(PRDATA),     32'd0);
    endtask

    initial begin
        logic [DW-1:0] w96;
        #1 CLEAR_B = 1'b0;
        #2 chk_reset_outputs("reset");
        repeat (3) @(negedge PCLK);
        CLEAR_B = 1'b1;
        @(posedge PCLK); #1;

        // single frame 0xA5
        push_tx(8'hA5, 1'b0);
        wr(8'hA5);
        wait_tx(200);
        repeat (4) @(posedge PCLK); #1;
        chk("idle_oe_b", 32'(SSPOE_B), 32'd1);
        chk("idle_txd",  32'(SSPTXD),  32'd0);

        // back-to-back frames chain through the LSB period
        push_tx(8'h3C, 1'b1);
        push_tx(8'hC3, 1'b0);
        wr(8'h3C);
        wr(8'hC3);
        wait_tx(400);

        // fill the Tx FIFO while 0x5A is on the wire; fifth write is dropped
        push_tx(8'h5A, 1'b1);
        wr(8'h5A);
        wait_fss(100);
        push_tx(8'h01, 1'b1);
        push_tx(8'h02, 1'b1);
        push_tx(8'h03, 1'b1);
        push_tx(8'h04, 1'b0);
        wr(8'h01);
        wr(8'h02);
        wr(8'h03);
        chk("txintr_after_3", 32'(SSPTXINTR), 32'd0);
        wr(8'h04);
        chk("txintr_after_4", 32'(SSPTXINTR), 32'd1);
        wr(8'h05);
        chk("txintr_after_5", 32'(SSPTXINTR), 32'd1);
        wait_tx(800);
        chk("txintr_drained", 32'(SSPTXINTR), 32'd0);

        // loopback fills the Rx FIFO
        lb_en = 1'b1;
        push_tx(8'h11, 1'b1);
        push_tx(8'h22, 1'b1);
        push_tx(8'h33, 1'b1);
        push_tx(8'h44, 1'b0);
        wr(8'h11);
        wr(8'h22);
        wr(8'h33);
        wr(8'h44);
        wait_tx(800);
        repeat (10) @(posedge PCLK); #1;
        lb_en = 1'b0;
        chk("rxintr_full", 32'(SSPRXINTR),  32'd1);
        chk("ror_no_ovr",  32'(SSPRORINTR), 32'd0);
        rd_exp(8'h11);
        rd_exp(8'h22);
        rd_exp(8'h33);
        rd_exp(8'h44);
        chk("rxintr_empty", 32'(SSPRXINTR), 32'd0);
        rd_exp(8'h00);
        chk("prdata_empty", 32'(PRDATA), 32'd0);

        // one frame more than the Rx FIFO holds
        lb_en = 1'b1;
        push_tx(8'h66, 1'b1);
        push_tx(8'h77, 1'b1);
        push_tx(8'h88, 1'b1);
        push_tx(8'h99, 1'b1);
        push_tx(8'hAB, 1'b0);
        wr(8'h66);
        wr(8'h77);
        wr(8'h88);
        wr(8'h99);
        wr(8'hAB);
        wait_tx(1000);
        repeat (10) @(posedge PCLK); #1;
        lb_en = 1'b0;
        chk("ovr_rxintr", 32'(SSPRXINTR),  32'd1);
        chk("ovr_ror",    32'(SSPRORINTR), 32'd1);
        repeat (20) @(posedge PCLK); #1;
        chk("ror_sticky", 32'(SSPRORINTR), 32'd1);
        rd_exp(8'h66);
        chk("ror_cleared", 32'(SSPRORINTR), 32'd0);
        rd_exp(8'h77);
        rd_exp(8'h88);
        rd_exp(8'h99);
        rd_exp(8'h00);

        // FSS mid-word restarts reception and drops the partial bits
        w96 = 8'h96;
        pin_bit(1'b1, 1'b0);
        repeat (3) pin_bit(1'b0, 1'b1);
        pin_bit(1'b1, 1'b0);
        for (int i = DW - 1; i >= 0; i--) pin_bit(1'b0, w96[i]);
        repeat (6) @(posedge PCLK); #1;
        chk("restart_ror", 32'(SSPRORINTR), 32'd0);
        rd_exp(8'h96);
        rd_exp(8'h00);

        // reset in the middle of bit 3 of 0xF0, with 0x77 still queued
        wr(8'hF0);
        wr(8'h77);
        wait_oe(100);
        repeat (6) @(posedge PCLK);
        #2;
        chk("pre_reset_txd",  32'(SSPTXD),  32'd1);
        chk("pre_reset_oe_b", 32'(SSPOE_B), 32'd0);
        CLEAR_B = 1'b0;
        #1 chk_reset_outputs("midframe");
        repeat (2) @(negedge PCLK);
        CLEAR_B = 1'b1;
        push_tx(8'h5C, 1'b0);
        wr(8'h5C);
        wait_tx(300);
        repeat (30) @(posedge PCLK); #1;
        chk("tx_queue_left", 32'(txq.size()), 32'd0);
        chk("rx_queue_left", 32'(rxq.size()), 32'd0);
        chk("final_oe_b",    32'(SSPOE_B),    32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
